sw_array_controller: RTL and testbench
======================================

# sw_array_controller

Host-side controller for the Smith-Waterman systolic PE array. It accepts an alignment job (target length), unpacks packed 2-bit target bases from a word stream, and feeds them gaplessly into PE0 with biased-zero boundary scores. It then detects end-of-computation from the last PE's valid flag and returns the unbiased best local score through a valid/ready result port.

## Interface
- SCORE_WIDTH, 12, score width in bits; must match the PE array
- LEN_WIDTH, 10, width of target length field
- WORD_BASES, 16, bases per target word; word width = 2*WORD_BASES
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- job_valid  in  1  job request
- job_ready  out  1  controller can accept a job
- job_len  in  LEN_WIDTH  target length in bases, 0 allowed
- tgt_valid  in  1  target word valid
- tgt_ready  out  1  target word accepted when both high
- tgt_data  in  2*WORD_BASES  packed bases, base k at bits [2k+1:2k], LSB-first
- pe_en  out  1  enable to PE0
- pe_data  out  2  target base to PE0 (A=00,G=01,T=10,C=11)
- pe_M, pe_I, pe_High  out  SCORE_WIDTH each  left-boundary scores, constant ZERO = 2^(SCORE_WIDTH-1)
- last_vld  in  1  vld of last PE (level; stays high until its next job starts)
- last_High  in  SCORE_WIDTH  High_out of last PE
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when both high
- res_score  out  SCORE_WIDTH  best score, unbiased two's complement
- res_len  out  LEN_WIDTH  bases actually streamed
- res_err  out  1  job aborted by target underrun

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, RESULT.
- IDLE: job_ready=1. On job_valid: latch len, words_needed=ceil(len/WORD_BASES), clear counters. If len=0 go RESULT with res_score=0, res_len=0, res_err=0. Otherwise go LOAD.
- LOAD: tgt_ready=1. First accepted word goes to the current-word shift register. Next state is STREAM.
- STREAM: pe_en=1 and pe_data=current base, exactly one base per cycle. Shift by 2 bits each cycle.
  - A second word register prefetches. tgt_ready=1 while next is empty and words_fetched<words_needed.
  - At a word boundary, next moves into current with no bubble.
  - After len bases, go DRAIN; pe_en=0 the following cycle.
  - Unused bases in the final partial word are ignored.
- Underrun: bases remain, current word is exhausted, and next is empty. Then pe_en=0 that cycle, err=1, res_len=bases sent, go DRAIN.
- DRAIN: pe_en=0. tgt_ready stays 1 until words_fetched==words_needed; late words of an aborted job are consumed and discarded. Wait for the last_vld rising edge (last_vld & ~last_vld_q) and that discard count. Then capture last_High and go RESULT.
- RESULT: res_valid=1, outputs held stable until res_ready, then IDLE.
- res_score = last_High - ZERO, which is {~last_High[MSB], last_High[MSB-1:0]}.
- Job acceptance is blocked until the result is consumed. This guarantees pe_en low for at least one cycle between jobs, which the PEs need to return to WAIT.

## Timing
- Reset values:
  - job_ready=0, tgt_ready=0, pe_en=0, pe_data=00, pe_M=pe_I=pe_High=ZERO
  - res_valid=0, res_score=0, res_len=0, res_err=0, last_vld_q=0, state IDLE
- All outputs are registered except job_ready and tgt_ready, which are decoded from state and counters.
- job handshake at cycle t → LOAD at t+1. First tgt handshake at cycle u → first pe_en high at u+1. pe_en then stays high for len consecutive cycles with a gapless upstream.
- last_vld rise at cycle v → res_valid at v+1.
- last_vld already high at DRAIN entry (left over from the previous job) is not an edge and must not trigger completion.
- Simultaneous tgt handshake and boundary swap in one cycle: the word is loaded into next after the swap; no loss.
- Reset mid-operation: return to reset values next cycle. The in-flight job and its result are lost; the array shares rst.

## Structure
- Shared package sw_pkg holds:
  - base encodings _A/_G/_T/_C
  - SCORE_WIDTH default and the ZERO bias function
  - the controller state enum
- Sub-module sw_target_unpacker: double-buffered word register plus shift-out logic, with inputs load/shift and outputs base/empty/next_full.
- FSM, counters, edge detector and result register sit in the top module.

## Test plan
- Job with len=5 and word 0x...00E4 (bases A,G,T,C,A): pe_en high for 5 cycles with pe_data 00,01,10,11,00. The stub raises last_vld with last_High=0x80A, giving res_score=10, res_len=5, res_err=0.
- len=40, three gapless words: 40 contiguous pe_en cycles with no bubble at the 16→17 and 32→33 boundaries. Exactly 3 words are accepted.
- len=40 with tgt_valid withheld after the first word: pe_en drops after 16 bases. The late 2 words are accepted and discarded, then res_err=1 and res_len=16.
- len=0: no pe_en and no tgt_ready pulse. Result 0/0/0 is presented 2 cycles after the job handshake.
- Back-to-back jobs with res_ready low for 10 cycles: job_ready stays 0 and the result stays stable. last_vld held high from job 1 does not complete job 2 early.
- rst asserted mid-STREAM: the next cycle shows all outputs at reset values. A following len=3 job completes normally.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman host controller and PE array:
// base encodings, score width and bias, controller states.
package sw_pkg;

  localparam logic [1:0] _A = 2'b00;
  localparam logic [1:0] _G = 2'b01;
  localparam logic [1:0] _T = 2'b10;
  localparam logic [1:0] _C = 2'b11;

  localparam int SCORE_WIDTH_DEF = 12;

  // Biased zero used by the PE array: 2^(width-1)
  function automatic logic [31:0] score_zero(input int unsigned width);
    return 32'h1 << (width - 1);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_RESULT
  } ctrl_state_t;

endpackage

// File: rtl/sw_array_controller_if.sv
// Host-side job, target-word and result handshakes of the SW array controller.
interface sw_array_controller_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int LEN_WIDTH   = 10,
  parameter int WORD_BASES  = 16
) ();
  logic                     job_valid;
  logic                     job_ready;
  logic [LEN_WIDTH-1:0]     job_len;
  logic                     tgt_valid;
  logic                     tgt_ready;
  logic [2*WORD_BASES-1:0]  tgt_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [SCORE_WIDTH-1:0]   res_score;
  logic [LEN_WIDTH-1:0]     res_len;
  logic                     res_err;

  modport master (
    output job_valid, job_len, tgt_valid, tgt_data, res_ready,
    input  job_ready, tgt_ready, res_valid, res_score, res_len, res_err
  );

  modport slave (
    input  job_valid, job_len, tgt_valid, tgt_data, res_ready,
    output job_ready, tgt_ready, res_valid, res_score, res_len, res_err
  );
endinterface

// File: rtl/sw_target_unpacker.sv
// Double-buffered target word register; shifts out one 2-bit base per shift.
// When both buffers are empty a shift takes its base straight from the loading word.
module sw_target_unpacker #(
  parameter int WORD_BASES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    shift,
  input  logic [2*WORD_BASES-1:0] data,
  output logic [1:0]              base,
  output logic                    empty,
  output logic                    next_full
);
  localparam int W  = 2 * WORD_BASES;
  localparam int CW = $clog2(WORD_BASES + 1);

  logic [W-1:0]  cur_word, nxt_word;
  logic [CW-1:0] cur_cnt;
  logic          nxt_full_q;
  logic          cur_avail, bypass, swap;

  assign cur_avail = (cur_cnt != '0);
  assign bypass    = shift && !cur_avail && !nxt_full_q;
  assign swap      = shift && !cur_avail && nxt_full_q;
  assign base      = cur_avail ? cur_word[1:0] : (nxt_full_q ? nxt_word[1:0] : data[1:0]);
  assign empty     = !cur_avail && !nxt_full_q;
  assign next_full = nxt_full_q;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cur_word   <= '0;
      nxt_word   <= '0;
      cur_cnt    <= '0;
      nxt_full_q <= 1'b0;
    end else begin
      if (shift) begin
        if (cur_avail) begin
          cur_word <= {2'b00, cur_word[W-1:2]};
          cur_cnt  <= cur_cnt - CW'(1);
        end else if (nxt_full_q) begin
          cur_word <= {2'b00, nxt_word[W-1:2]};
          cur_cnt  <= CW'(WORD_BASES - 1);
        end else begin
          cur_word <= {2'b00, data[W-1:2]};
          cur_cnt  <= CW'(WORD_BASES - 1);
        end
      end
      // A word arriving during a swap lands in the freshly vacated next buffer
      if (load && !bypass) begin
        nxt_word   <= data;
        nxt_full_q <= 1'b1;
      end else if (swap) begin
        nxt_full_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sw_array_controller.sv
// Host controller for the SW systolic array: streams target bases into PE0 and
// returns the unbiased best score once the last PE signals completion.
//   state     | meaning
//   ST_IDLE   | ready for a job
//   ST_LOAD   | waiting for the first target word
//   ST_STREAM | one base per cycle into PE0, prefetching the next word
//   ST_DRAIN  | waiting for last PE vld rise and any late words
//   ST_RESULT | result held until accepted
module sw_array_controller
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = SCORE_WIDTH_DEF,
  parameter int LEN_WIDTH   = 10,
  parameter int WORD_BASES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sw_array_controller_if.slave   host,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic                   last_vld,
  input  logic [SCORE_WIDTH-1:0] last_High
);
  localparam logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(score_zero(SCORE_WIDTH));

  ctrl_state_t state, state_nxt;

  logic [LEN_WIDTH-1:0]   len_q, bases_left, words_left, words_calc;
  logic [LEN_WIDTH:0]     len_round;
  logic                   last_vld_q, edge_seen, err_q, rise;
  logic                   job_rdy, tgt_rdy, tgt_hs;
  logic                   clear, load, shift, send, underrun, done;
  logic [1:0]             base;
  logic                   empty, next_full;
  logic                   res_valid_q, res_err_q;
  logic [SCORE_WIDTH-1:0] res_score_q;
  logic [LEN_WIDTH-1:0]   res_len_q;

  assign len_round  = {1'b0, host.job_len} + (LEN_WIDTH+1)'(WORD_BASES - 1);
  assign words_calc = LEN_WIDTH'(len_round / (LEN_WIDTH+1)'(WORD_BASES));
  assign rise       = last_vld & ~last_vld_q;

  assign host.job_ready = job_rdy & rst;
  assign host.tgt_ready = tgt_rdy & rst;
  assign tgt_hs         = host.tgt_valid & host.tgt_ready;

  assign host.res_valid = res_valid_q;
  assign host.res_score = res_score_q;
  assign host.res_len   = res_len_q;
  assign host.res_err   = res_err_q;

  assign pe_M    = ZERO;
  assign pe_I    = ZERO;
  assign pe_High = ZERO;

  sw_target_unpacker #(.WORD_BASES(WORD_BASES)) u_unpack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .shift     (shift),
    .data      (host.tgt_data),
    .base      (base),
    .empty     (empty),
    .next_full (next_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    job_rdy   = 1'b0;
    tgt_rdy   = 1'b0;
    clear     = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    send      = 1'b0;
    underrun  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        job_rdy = 1'b1;
        if (host.job_valid) begin
          clear     = 1'b1;
          state_nxt = (host.job_len == '0) ? ST_RESULT : ST_LOAD;
        end
      end
      ST_LOAD: begin
        tgt_rdy = 1'b1;
        if (host.tgt_valid) begin
          load      = 1'b1;
          shift     = 1'b1;
          send      = 1'b1;
          state_nxt = (bases_left == LEN_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        tgt_rdy = !next_full && (words_left != '0);
        load    = host.tgt_valid && tgt_rdy;
        if (!empty) begin
          shift = 1'b1;
          send  = 1'b1;
          if (bases_left == LEN_WIDTH'(1)) state_nxt = ST_DRAIN;
        end else begin
          underrun  = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tgt_rdy = (words_left != '0);
        done    = (edge_seen || rise) && (words_left == '0);
        if (done) state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        if (host.res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pe_en       <= 1'b0;
      pe_data     <= 2'b00;
      len_q       <= '0;
      bases_left  <= '0;
      words_left  <= '0;
      last_vld_q  <= 1'b0;
      edge_seen   <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_score_q <= '0;
      res_len_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      last_vld_q <= last_vld;
      pe_en      <= send;
      if (send) pe_data <= base;

      if (clear) begin
        len_q      <= host.job_len;
        bases_left <= host.job_len;
        words_left <= words_calc;
        edge_seen  <= 1'b0;
        err_q      <= 1'b0;
      end
      if (send)     bases_left <= bases_left - LEN_WIDTH'(1);
      if (tgt_hs)   words_left <= words_left - LEN_WIDTH'(1);
      if (underrun) err_q      <= 1'b1;

      // Only a rise seen while draining belongs to this job
      if (state == ST_DRAIN && rise) begin
        edge_seen   <= 1'b1;
        res_score_q <= {~last_High[SCORE_WIDTH-1], last_High[SCORE_WIDTH-2:0]};
      end

      if (clear && host.job_len == '0) begin
        res_valid_q <= 1'b1;
        res_score_q <= '0;
        res_len_q   <= '0;
        res_err_q   <= 1'b0;
      end else if (done) begin
        res_valid_q <= 1'b1;
        res_len_q   <= len_q - bases_left;
        res_err_q   <= err_q;
      end else if (state == ST_RESULT && host.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sw_array_controller.sv
// Directed bench for sw_array_controller with a word-source model and a last-PE stub.
module tb_sw_array_controller;
  import sw_pkg::*;

  logic        clk;
  logic        rst;
  logic        pe_en;
  logic [1:0]  pe_data;
  logic [11:0] pe_M, pe_I, pe_High;
  logic        last_vld;
  logic [11:0] last_High;

  sw_array_controller_if #(.SCORE_WIDTH(12), .LEN_WIDTH(10), .WORD_BASES(16)) bus ();

  sw_array_controller #(.SCORE_WIDTH(12), .LEN_WIDTH(10), .WORD_BASES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus),
    .pe_en     (pe_en),
    .pe_data   (pe_data),
    .pe_M      (pe_M),
    .pe_I      (pe_I),
    .pe_High   (pe_High),
    .last_vld  (last_vld),
    .last_High (last_High)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;
  int n_pe, n_words, n_rdy, pe_rises;
  bit feed;
  bit pe_en_prev;
  logic [31:0] words[$];
  logic [1:0]  bases[$];
  logic [31:0] exp_words[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    n_pe = 0; n_words = 0; n_rdy = 0; pe_rises = 0;
    bases.delete();
  endtask

  // One clock: present source word, note handshake, then sample outputs 1 after the edge
  task automatic tick();
    bit hs;
    bus.tgt_valid = feed && (words.size() != 0);
    bus.tgt_data  = (words.size() != 0) ? words[0] : 32'h0;
    #1;
    hs = bus.tgt_valid && bus.tgt_ready;
    if (bus.tgt_ready) n_rdy++;
    @(posedge clk);
    #1;
    if (hs) begin
      words.delete(0);
      n_words++;
    end
    if (pe_en) begin
      bases.push_back(pe_data);
      if (!pe_en_prev) pe_rises++;
      n_pe++;
    end
    pe_en_prev = pe_en;
  endtask

  task automatic run_stream(input string tag);
    int k;
    k = 0;
    while (pe_en && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_stream_bound"}, 32'(k < 200), 32'd1);
  endtask

  task automatic check_bases(input string tag, input int len);
    int bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < len && i < bases.size(); i++) begin
      w = exp_words[i / 16];
      if (bases[i] !== w[2*(i%16) +: 2]) bad++;
    end
    check({tag, "_base_mismatches"}, 32'(bad), 32'd0);
  endtask

  task automatic consume_result();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  logic [11:0] snap_score;
  logic [9:0]  snap_len;
  logic        snap_err;
  int          unstable, jr_high, k;

  initial begin
    rst = 1'b0;
    feed = 1'b0;
    pe_en_prev = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len   = '0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    bus.res_ready = 1'b0;
    last_vld  = 1'b0;
    last_High = '0;
    reset_stats();

    // Reset values
    tick();
    tick();
    check("rst_job_ready", 32'(bus.job_ready), 32'd0);
    check("rst_tgt_ready", 32'(bus.tgt_ready), 32'd0);
    check("rst_pe_en", 32'(pe_en), 32'd0);
    check("rst_pe_data", 32'(pe_data), 32'd0);
    check("rst_pe_M", 32'(pe_M), 32'h800);
    check("rst_pe_I", 32'(pe_I), 32'h800);
    check("rst_pe_High", 32'(pe_High), 32'h800);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_score", 32'(bus.res_score), 32'd0);
    check("rst_res_len", 32'(bus.res_len), 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);
    rst = 1'b1;
    #1;
    check("idle_job_ready", 32'(bus.job_ready), 32'd1);

    // Job 1: len=5, bases A,G,T,C,A
    reset_stats();
    exp_words[0] = 32'h0000_00E4;
    words = '{32'h0000_00E4};
    feed = 1'b1;
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd5;
    tick();
    bus.job_valid = 1'b0;
    check("t1_load_tgt_ready", 32'(bus.tgt_ready), 32'd1);
    check("t1_load_job_ready", 32'(bus.job_ready), 32'd0);
    tick();
    check("t1_first_pe_en", 32'(pe_en), 32'd1);
    check("t1_first_pe_data", 32'(pe_data), 32'(_A));
    run_stream("t1");
    check("t1_pe_cycles", 32'(n_pe), 32'd5);
    check("t1_pe_rises", 32'(pe_rises), 32'd1);
    check_bases("t1", 5);
    tick();
    check("t1_wait_res_valid", 32'(bus.res_valid), 32'd0);
    last_vld  = 1'b1;
    last_High = 12'h80A;
    tick();
    check("t1_res_valid", 32'(bus.res_valid), 32'd1);
    check("t1_res_score", 32'(bus.res_score), 32'd10);
    check("t1_res_len", 32'(bus.res_len), 32'd5);
    check("t1_res_err", 32'(bus.res_err), 32'd0);
    tick();
    tick();
    check("t1_res_hold", 32'(bus.res_valid), 32'd1);
    consume_result();
    check("t1_res_dropped", 32'(bus.res_valid), 32'd0);
    check("t1_idle_again", 32'(bus.job_ready), 32'd1);

    // Job 2: len=40 gapless over three words; last_vld left high from job 1
    reset_stats();
    exp_words[0] = 32'hE4E4_E4E4;
    exp_words[1] = 32'h1B1B_1B1B;
    exp_words[2] = 32'hFFFF_5555;
    words = '{32'hE4E4_E4E4, 32'h1B1B_1B1B, 32'hFFFF_5555};
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd40;
    tick();
    bus.job_valid = 1'b0;
    tick();
    check("t2_first_pe_en", 32'(pe_en), 32'd1);
    last_vld = 1'b0;
    run_stream("t2");
    check("t2_pe_cycles", 32'(n_pe), 32'd40);
    check("t2_no_bubble", 32'(pe_rises), 32'd1);
    check("t2_words", 32'(n_words), 32'd3);
    check_bases("t2", 40);
    last_vld  = 1'b1;
    last_High = 12'h7FB;
    tick();
    check("t2_res_valid", 32'(bus.res_valid), 32'd1);
    check("t2_res_score", 32'(bus.res_score), 32'hFFB);
    check("t2_res_len", 32'(bus.res_len), 32'd40);
    check("t2_res_err", 32'(bus.res_err), 32'd0);

    // Back-to-back: next job waits while the result is unconsumed
    snap_score = bus.res_score;
    snap_len   = bus.res_len;
    snap_err   = bus.res_err;
    unstable = 0;
    jr_high  = 0;
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd40;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.job_ready) jr_high++;
      tick();
      if (!bus.res_valid || bus.res_score !== snap_score || bus.res_len !== snap_len ||
          bus.res_err !== snap_err) unstable++;
    end
    check("b2b_job_ready_low", 32'(jr_high), 32'd0);
    check("b2b_result_stable", 32'(unstable), 32'd0);
    consume_result();

    // Job 3: len=40, only the first word arrives in time; last_vld still high
    reset_stats();
    exp_words[0] = 32'h3C96_A5F0;
    words = '{32'h3C96_A5F0};
    tick();
    bus.job_valid = 1'b0;
    tick();
    check("t3_first_pe_en", 32'(pe_en), 32'd1);
    run_stream("t3");
    check("t3_pe_cycles", 32'(n_pe), 32'd16);
    check_bases("t3", 16);
    words.push_back(32'h1111_1111);
    words.push_back(32'h2222_2222);
    k = 0;
    while (n_words < 3 && k < 20) begin
      tick();
      k++;
    end
    check("t3_late_words", 32'(n_words), 32'd3);
    tick();
    tick();
    check("t3_no_early_done", 32'(bus.res_valid), 32'd0);
    check("t3_drain_pe_en", 32'(pe_en), 32'd0);
    last_vld = 1'b0;
    tick();
    check("t3_no_done_on_fall", 32'(bus.res_valid), 32'd0);
    last_vld  = 1'b1;
    last_High = 12'h900;
    tick();
    check("t3_res_valid", 32'(bus.res_valid), 32'd1);
    check("t3_res_err", 32'(bus.res_err), 32'd1);
    check("t3_res_len", 32'(bus.res_len), 32'd16);
    check("t3_res_score", 32'(bus.res_score), 32'h100);
    consume_result();

    // Reset in the middle of streaming
    reset_stats();
    words = '{32'hE4E4_E4E4, 32'h1B1B_1B1B, 32'hFFFF_5555};
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd40;
    tick();
    bus.job_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rs_streaming", 32'(pe_en), 32'd1);
    rst = 1'b0;
    feed = 1'b0;
    words.delete();
    tick();
    check("rs_job_ready", 32'(bus.job_ready), 32'd0);
    check("rs_tgt_ready", 32'(bus.tgt_ready), 32'd0);
    check("rs_pe_en", 32'(pe_en), 32'd0);
    check("rs_pe_data", 32'(pe_data), 32'd0);
    check("rs_res_valid", 32'(bus.res_valid), 32'd0);
    check("rs_res_score", 32'(bus.res_score), 32'd0);
    check("rs_res_len", 32'(bus.res_len), 32'd0);
    check("rs_res_err", 32'(bus.res_err), 32'd0);
    rst = 1'b1;
    last_vld = 1'b0;

    // Job after reset: len=3, bases G,T,C
    reset_stats();
    exp_words[0] = 32'h0000_0039;
    words = '{32'h0000_0039};
    feed = 1'b1;
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd3;
    tick();
    bus.job_valid = 1'b0;
    tick();
    check("t5_first_pe_data", 32'(pe_data), 32'(_G));
    run_stream("t5");
    check("t5_pe_cycles", 32'(n_pe), 32'd3);
    check_bases("t5", 3);
    last_vld  = 1'b1;
    last_High = 12'h803;
    tick();
    check("t5_res_valid", 32'(bus.res_valid), 32'd1);
    check("t5_res_score", 32'(bus.res_score), 32'd3);
    check("t5_res_len", 32'(bus.res_len), 32'd3);
    check("t5_res_err", 32'(bus.res_err), 32'd0);
    consume_result();

    // len=0: no streaming, immediate 0/0/0 result
    reset_stats();
    bus.job_valid = 1'b1;
    bus.job_len   = 10'd0;
    tick();
    bus.job_valid = 1'b0;
    tick();
    check("t4_res_valid", 32'(bus.res_valid), 32'd1);
    check("t4_res_score", 32'(bus.res_score), 32'd0);
    check("t4_res_len", 32'(bus.res_len), 32'd0);
    check("t4_res_err", 32'(bus.res_err), 32'd0);
    check("t4_no_pe_en", 32'(n_pe), 32'd0);
    check("t4_no_tgt_ready", 32'(n_rdy), 32'd0);
    consume_result();
    check("t4_idle", 32'(bus.job_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
